// File: rtl/risc_pkg.sv
// Shared definitions for the RISC boot-time program loader.
package risc_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_e;

endpackage

// File: rtl/risc_loader_assembler.sv
// Packs payload bytes little-endian into 32-bit words and keeps the running XOR checksum.
module risc_loader_assembler
    import risc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic              word_done,
    output logic              word_ready,
    output logic [WORD_W-1:0] word,
    output logic [7:0]        csum
);

    logic [1:0]        idx_q;
    logic [23:0]       shift_q;
    logic [WORD_W-1:0] word_q;
    logic              word_ready_q;
    logic [7:0]        csum_q;

    // Combinational: the byte being accepted right now completes a word.
    assign word_done = byte_en && (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_ready_q <= 1'b0;
            csum_q       <= '0;
        end else if (clr) begin
            idx_q        <= '0;
            word_ready_q <= 1'b0;
            csum_q       <= '0;
        end else begin
            word_ready_q <= word_done;
            if (byte_en) begin
                idx_q  <= idx_q + 2'd1;
                csum_q <= csum_q ^ byte_in;
                unique case (idx_q)
                    2'd0: shift_q[7:0]   <= byte_in;
                    2'd1: shift_q[15:8]  <= byte_in;
                    2'd2: shift_q[23:16] <= byte_in;
                    2'd3: word_q         <= {byte_in, shift_q};
                endcase
            end
        end
    end

    assign word_ready = word_ready_q;
    assign word       = word_q;
    assign csum       = csum_q;

endmodule

// File: rtl/risc_program_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte image, writes it to instruction
// memory and releases the core from reset once the checksum matches.
module risc_program_loader
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   wcnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       len_full;
    logic              fire, byte_en, clr, word_done;
    logic [7:0]        csum;
    logic              in_ready_q, core_rst_q, load_done_q, load_err_q;
    logic              in_ready_d, core_rst_d, load_done_d, load_err_d;

    assign fire     = in_valid && in_ready_q;
    assign len_full = {in_data, len_lo_q};
    assign byte_en  = fire && (state_q == DATA);
    assign clr      = (state_q == RUN) && reload;

    risc_loader_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .byte_en    (byte_en),
        .byte_in    (in_data),
        .word_done  (word_done),
        .word_ready (imem_we),
        .word       (imem_wdata),
        .csum       (csum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LEN0;
            len_lo_q <= '0;
            len_q    <= '0;
            wcnt_q   <= '0;
            addr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (fire && state_q == LEN0) len_lo_q <= in_data;
            if (fire && state_q == LEN1) len_q <= len_full[ADDR_W:0];
            if (word_done) begin
                addr_q <= wcnt_q[ADDR_W-1:0];
                wcnt_q <= wcnt_q + (ADDR_W + 1)'(1);
            end
            if (clr) wcnt_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN0: if (fire) state_d = LEN1;
            LEN1: begin
                if (fire) begin
                    if (32'(len_full) > MAX_WORDS) state_d = ERR;
                    else if (len_full == '0)       state_d = CSUM;
                    else                           state_d = DATA;
                end
            end
            DATA: if (word_done && (wcnt_q + (ADDR_W + 1)'(1)) == len_q) state_d = CSUM;
            CSUM: if (fire) state_d = (in_data == csum) ? RUN : ERR;
            RUN:  if (reload) state_d = LEN0;
            ERR:  state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // Flags are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        in_ready_d  = (state_d == LEN0) || (state_d == LEN1) ||
                      (state_d == DATA) || (state_d == CSUM);
        core_rst_d  = (state_d != RUN);
        load_done_d = (state_d == RUN);
        load_err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            core_rst_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            core_rst_q  <= core_rst_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign core_rst  = core_rst_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign imem_addr = addr_q;

endmodule

// File: tb/tb_risc_program_loader.sv
// Directed + randomized bench for risc_program_loader (ADDR_W=4, 16-word memory).
module tb_risc_program_loader;

    localparam int unsigned AW   = 4;
    localparam int          MAXW = 16;

    logic          clk = 1'b0;
    logic          rst, in_valid, reload, in_ready;
    logic [7:0]    in_data;
    logic          imem_we, core_rst, load_done, load_err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    int n_cmp = 0;
    int n_err = 0;
    int we_count = 0;
    logic [31:0] words [0:MAXW];

    always #5 clk = ~clk;

    risc_program_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always @(posedge clk) if (imem_we === 1'b1) we_count++;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference checksum: XOR of every payload byte of the first n words.
    function automatic logic [7:0] model_csum(input int n);
        logic [7:0] c = 8'h00;
        for (int w = 0; w < n; w++)
            for (int k = 0; k < 4; k++) c ^= words[w][8*k +: 8];
        return c;
    endfunction

    task automatic run_frame(input int n, input logic [7:0] cs, input int max_gap,
                             input string tag);
        logic ok;
        int   base;
        ok   = (n <= MAXW) && (cs == model_csum(n));
        base = we_count;
        send_byte(n[7:0], max_gap);
        send_byte(n[15:8], max_gap);
        if (n > MAXW) begin
            chk({tag, "_len_err"}, 32'(load_err), 32'(1));
            chk({tag, "_len_rdy"}, 32'(in_ready), 32'(0));
            chk({tag, "_len_crst"}, 32'(core_rst), 32'(1));
            repeat (3) @(negedge clk);
            chk({tag, "_len_nowr"}, 32'(we_count - base), 32'(0));
            return;
        end
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(words[w][8*k +: 8], max_gap);
                if (k == 3) begin
                    chk({tag, "_we"}, 32'(imem_we), 32'(1));
                    chk({tag, "_addr"}, 32'(imem_addr), 32'(w));
                    chk({tag, "_data"}, imem_wdata, words[w]);
                end
            end
        end
        chk({tag, "_crst_pre"}, 32'(core_rst), 32'(1));
        send_byte(cs, max_gap);
        chk({tag, "_crst"}, 32'(core_rst), 32'(!ok));
        chk({tag, "_done"}, 32'(load_done), 32'(ok));
        chk({tag, "_err"}, 32'(load_err), 32'(!ok));
        chk({tag, "_rdy"}, 32'(in_ready), 32'(0));
        chk({tag, "_nwr"}, 32'(we_count - base), 32'(n));
    endtask

    initial begin
        int base;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(in_ready), 32'(1));
        chk("rst_we", 32'(imem_we), 32'(0));
        chk("rst_addr", 32'(imem_addr), 32'(0));
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_crst", 32'(core_rst), 32'(1));
        chk("rst_done", 32'(load_done), 32'(0));
        chk("rst_err", 32'(load_err), 32'(0));
        rst = 1'b0;

        // Two-word image, back-to-back and then with random gaps.
        words[0] = 32'h12345678;
        words[1] = 32'hDEADBEEF;
        run_frame(2, model_csum(2), 0, "s1");
        do_reset();
        run_frame(2, model_csum(2), 3, "s1gap");

        // Bad checksum; error is sticky and ignores traffic and reload.
        do_reset();
        run_frame(2, 8'h5A, 0, "s2");
        base = we_count;
        for (int i = 0; i < 8; i++) begin
            in_data  = 8'($urandom());
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        reload   = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        @(negedge clk);
        chk("s2_err_hold", 32'(load_err), 32'(1));
        chk("s2_rdy_hold", 32'(in_ready), 32'(0));
        chk("s2_crst_hold", 32'(core_rst), 32'(1));
        chk("s2_done_hold", 32'(load_done), 32'(0));
        chk("s2_nowr", 32'(we_count - base), 32'(0));

        // Empty image.
        do_reset();
        run_frame(0, model_csum(0), 0, "s3");

        // Length above capacity, then exactly at capacity.
        do_reset();
        run_frame(17, 8'h00, 0, "s4a");
        do_reset();
        for (int i = 0; i < MAXW; i++) words[i] = $urandom();
        run_frame(16, model_csum(16), 0, "s4b");

        // Reset mid-load, coinciding with a word-completing byte.
        do_reset();
        words[0] = $urandom();
        words[1] = $urandom();
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        for (int i = 0; i < 7; i++) send_byte(words[i / 4][8*(i % 4) +: 8], 0);
        in_data  = words[1][31:24];
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        base     = we_count;
        chk("s5_we", 32'(imem_we), 32'(0));
        chk("s5_rdy", 32'(in_ready), 32'(1));
        chk("s5_crst", 32'(core_rst), 32'(1));
        chk("s5_addr", 32'(imem_addr), 32'(0));
        chk("s5_wdata", imem_wdata, 32'h0);
        repeat (6) @(negedge clk);
        chk("s5_nowr", 32'(we_count - base), 32'(0));
        words[0] = $urandom();
        run_frame(1, model_csum(1), 2, "s5b");

        // Reload from RUN and load a second image with random gaps.
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("s6_crst", 32'(core_rst), 32'(1));
        chk("s6_rdy", 32'(in_ready), 32'(1));
        chk("s6_done", 32'(load_done), 32'(0));
        for (int i = 0; i < 3; i++) words[i] = $urandom();
        run_frame(3, model_csum(3), 3, "s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
